sipo_deserializer: RTL and testbench

Serial-In-Parallel-Out stage directly downstream of the PISO serializer. It consumes the PISO's serial bit stream and per-bit valid, which carry LSB-first DATA_WIDTH-bit packets, and reassembles each packet into a parallel word. Each word is presented on a valid/ready output port. The block also detects aborted frames and dropped words, so the receive side of the link can be checked end to end.

---
 rtl/sipo_deserializer_if.sv | 53 +++++
 rtl/sipo_deserializer.sv | 162 ++++++++++++++++
 tb/tb_sipo_deserializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deserializer_if.sv
// ----------------------------------------------------------------------------
// sipo_deserializer_if
//
// Groups the serial input stream, the parallel valid/ready output port and the
// status pulses of the SIPO deserializer into a single bundle.
//
//   serial_in  : serial data bit, LSB first, qualified by valid_in
//   valid_in   : qualifies serial_in in the current cycle
//   data_out   : assembled DATA_WIDTH-bit word
//   valid_out  : word held for the consumer
//   ready_in   : consumer accepts the word when valid_out && ready_in
//   busy       : a frame is partially received
//   frame_err  : one-cycle pulse when a frame is aborted by an over-long gap
//   overflow   : one-cycle pulse when a completed word is dropped
//
// Modports:
//   master : upstream serializer + downstream consumer side
//   slave  : the deserializer itself
// ----------------------------------------------------------------------------
interface sipo_deserializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  serial_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  busy;
    logic                  frame_err;
    logic                  overflow;

    modport master (
        output serial_in,
        output valid_in,
        output ready_in,
        input  data_out,
        input  valid_out,
        input  busy,
        input  frame_err,
        input  overflow
    );

    modport slave (
        input  serial_in,
        input  valid_in,
        input  ready_in,
        output data_out,
        output valid_out,
        output busy,
        output frame_err,
        output overflow
    );
endinterface

// File: rtl/sipo_deserializer.sv
// ----------------------------------------------------------------------------
// sipo_deserializer
//
// Serial-in / parallel-out stage. Reassembles LSB-first DATA_WIDTH-bit packets
// from a serial stream with per-bit valid and presents each word on a
// valid/ready output port. Frames that stall for more than MAX_GAP
// consecutive invalid cycles are aborted (frame_err), and a completed word
// that cannot be handed over because the previous one is still held is
// dropped (overflow).
//
// Parameters:
//   DATA_WIDTH : packet width in bits (>= 2)
//   MAX_GAP    : number of consecutive valid_in-low cycles tolerated in a frame
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : sipo_deserializer_if.slave (serial input, parallel output, status)
// ----------------------------------------------------------------------------
module sipo_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_GAP    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    sipo_deserializer_if.slave    bus
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  complete;
    logic                  abort;

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  vld_p1;
    logic                  busy_p1;
    logic                  frame_err_p1;
    logic                  overflow_p1;

    // Right shift with the new bit entering the MSB: after DATA_WIDTH valid
    // bits the first one has walked down to bit 0, so bit k of the frame
    // ends up in data bit k. On the completing bit this is the full word.
    assign shifted = {bus.serial_in, shreg_q[DATA_WIDTH-1:1]};

    // ------------------------------------------------------------------------
    // Stage 0: input FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        complete  = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    shreg_d   = shifted;
                    bit_cnt_d = CNT_W'(1);
                    gap_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                if (bus.valid_in) begin
                    shreg_d   = shifted;
                    gap_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        complete  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    // Gap exceeded the tolerance: throw the partial word away.
                    abort     = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    shreg_d   = '0;
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                gap_cnt_d = '0;
                shreg_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: output word register, handshake and status pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            data_p1      <= '0;
            vld_p1       <= 1'b0;
            busy_p1      <= 1'b0;
            frame_err_p1 <= 1'b0;
            overflow_p1  <= 1'b0;
        end else begin
            busy_p1      <= (state_d == SHIFT);
            frame_err_p1 <= abort;
            overflow_p1  <= 1'b0;

            if (complete) begin
                // A word being consumed this cycle frees the slot, so the new
                // word can take its place without a bubble.
                if (!vld_p1 || bus.ready_in) begin
                    data_p1 <= shifted;
                    vld_p1  <= 1'b1;
                end else begin
                    overflow_p1 <= 1'b1;
                end
            end else if (vld_p1 && bus.ready_in) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.data_out  = data_p1;
    assign bus.valid_out = vld_p1;
    assign bus.busy      = busy_p1;
    assign bus.frame_err = frame_err_p1;
    assign bus.overflow  = overflow_p1;

endmodule

// File: tb/tb_sipo_deserializer.sv
// ----------------------------------------------------------------------------
// tb_sipo_deserializer
//
// Drives two deserializers (MAX_GAP=0 and MAX_GAP=2) from the same stimulus.
// Gap-free scenarios come from a cycle table whose rows hold the inputs for
// one clock and the outputs expected just after that edge; the gap scenarios
// are hand-written sequences checking each instance separately.
// ----------------------------------------------------------------------------
module tb_sipo_deserializer;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sin;
    logic vin;
    logic rdy;

    sipo_deserializer_if #(.DATA_WIDTH(W)) bus0 ();
    sipo_deserializer_if #(.DATA_WIDTH(W)) bus2 ();

    assign bus0.serial_in = sin;
    assign bus0.valid_in  = vin;
    assign bus0.ready_in  = rdy;
    assign bus2.serial_in = sin;
    assign bus2.valid_in  = vin;
    assign bus2.ready_in  = rdy;

    sipo_deserializer #(.DATA_WIDTH(W), .MAX_GAP(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    sipo_deserializer #(.DATA_WIDTH(W), .MAX_GAP(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic       rst;
        logic       vin;
        logic       sin;
        logic       rdy;
        logic       vout;
        logic [7:0] data;
        logic       busy;
        logic       ferr;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic s, input logic y);
        rst = r;
        vin = v;
        sin = s;
        rdy = y;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic y,
                       input logic vo, input logic [7:0] d, input logic b,
                       input logic f, input logic o);
        vec_t e;
        e.rst = r; e.vin = v; e.sin = s; e.rdy = y;
        e.vout = vo; e.data = d; e.busy = b; e.ferr = f; e.ovf = o;
        vecs.push_back(e);
    endtask

    // Eight consecutive valid bits of w (LSB first). Bits 0..6 expect busy=1
    // and the given held output; the last bit expects busy=0 and the result.
    task automatic add_frame(input logic [7:0] w, input logic y, input logic last_y,
                             input logic mid_vout, input logic [7:0] mid_data,
                             input logic last_vout, input logic [7:0] last_data,
                             input logic last_ovf);
        for (int i = 0; i < 8; i++) begin
            if (i < 7)
                add(1'b0, 1'b1, w[i], y, mid_vout, mid_data, 1'b1, 1'b0, 1'b0);
            else
                add(1'b0, 1'b1, w[i], last_y, last_vout, last_data, 1'b0, 1'b0, last_ovf);
        end
    endtask

    task automatic send_bits(input logic [7:0] w, input int first, input int last, input logic y);
        for (int i = first; i <= last; i++) step(1'b0, 1'b1, w[i], y);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        sin = 1'b0;
        rdy = 1'b1;

        // Reset
        add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // Single 0x73, ready high
        add_frame(8'h73, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h73, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h73, 1'b0, 1'b0, 1'b0);
        // Back-to-back 0x73, 0x1F
        add_frame(8'h73, 1'b1, 1'b1, 1'b0, 8'h73, 1'b1, 8'h73, 1'b0);
        add_frame(8'h1F, 1'b1, 1'b1, 1'b0, 8'h73, 1'b1, 8'h1F, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);
        // Consumer stalled: 0x73 held, 0x1F dropped, then drained
        add_frame(8'h73, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b1, 8'h73, 1'b0);
        add_frame(8'h1F, 1'b0, 1'b0, 1'b1, 8'h73, 1'b1, 8'h73, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h73, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h73, 1'b0, 1'b0, 1'b0);
        // Held 0x73 consumed in the same cycle 0x1F completes
        add_frame(8'h73, 1'b0, 1'b0, 1'b0, 8'h73, 1'b1, 8'h73, 1'b0);
        add_frame(8'h1F, 1'b0, 1'b1, 1'b1, 8'h73, 1'b1, 8'h1F, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);
        // Reset after 4 bits of 0x73, then a clean 0x1F
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        add_frame(8'h1F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 8'h1F, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vin, vecs[i].sin, vecs[i].rdy);
            chk($sformatf("row%0d g0 valid_out", i), 32'(bus0.valid_out), 32'(vecs[i].vout));
            chk($sformatf("row%0d g0 data_out",  i), 32'(bus0.data_out),  32'(vecs[i].data));
            chk($sformatf("row%0d g0 busy",      i), 32'(bus0.busy),      32'(vecs[i].busy));
            chk($sformatf("row%0d g0 frame_err", i), 32'(bus0.frame_err), 32'(vecs[i].ferr));
            chk($sformatf("row%0d g0 overflow",  i), 32'(bus0.overflow),  32'(vecs[i].ovf));
            chk($sformatf("row%0d g2 valid_out", i), 32'(bus2.valid_out), 32'(vecs[i].vout));
            chk($sformatf("row%0d g2 data_out",  i), 32'(bus2.data_out),  32'(vecs[i].data));
            chk($sformatf("row%0d g2 busy",      i), 32'(bus2.busy),      32'(vecs[i].busy));
            chk($sformatf("row%0d g2 frame_err", i), 32'(bus2.frame_err), 32'(vecs[i].ferr));
            chk($sformatf("row%0d g2 overflow",  i), 32'(bus2.overflow),  32'(vecs[i].ovf));
        end

        // One-cycle gap after 3 bits: MAX_GAP=0 aborts, MAX_GAP=2 keeps going
        send_bits(8'h07, 0, 2, 1'b1);
        chk("gap1 g0 busy before gap", 32'(bus0.busy), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap1 g0 frame_err",  32'(bus0.frame_err), 32'd1);
        chk("gap1 g0 busy",       32'(bus0.busy),      32'd0);
        chk("gap1 g0 valid_out",  32'(bus0.valid_out), 32'd0);
        chk("gap1 g2 frame_err",  32'(bus2.frame_err), 32'd0);
        chk("gap1 g2 busy",       32'(bus2.busy),      32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap1 g0 frame_err pulse end", 32'(bus0.frame_err), 32'd0);
        chk("gap1 g2 frame_err 2nd gap",   32'(bus2.frame_err), 32'd0);
        send_bits(8'h1F, 0, 7, 1'b1);
        chk("after abort g0 valid_out", 32'(bus0.valid_out), 32'd1);
        chk("after abort g0 data_out",  32'(bus0.data_out),  32'h1F);
        chk("after abort g0 frame_err", 32'(bus0.frame_err), 32'd0);

        // Two-cycle gap after bit 4 of 0x73 is tolerated with MAX_GAP=2
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst g2 valid_out", 32'(bus2.valid_out), 32'd0);
        chk("rst g2 data_out",  32'(bus2.data_out),  32'h00);
        send_bits(8'h73, 0, 4, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap2 g0 frame_err", 32'(bus0.frame_err), 32'd1);
        chk("gap2 g2 frame_err a", 32'(bus2.frame_err), 32'd0);
        chk("gap2 g2 busy a",      32'(bus2.busy),      32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap2 g2 frame_err b", 32'(bus2.frame_err), 32'd0);
        chk("gap2 g2 busy b",      32'(bus2.busy),      32'd1);
        send_bits(8'h73, 5, 7, 1'b1);
        chk("gap2 g2 frame_err end", 32'(bus2.frame_err), 32'd0);
        chk("gap2 g2 valid_out",     32'(bus2.valid_out), 32'd1);
        chk("gap2 g2 data_out",      32'(bus2.data_out),  32'h73);
        chk("gap2 g2 busy end",      32'(bus2.busy),      32'd0);

        // Three-cycle gap exceeds MAX_GAP=2
        step(1'b1, 1'b0, 1'b0, 1'b1);
        send_bits(8'h07, 0, 2, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap3 g2 frame_err a", 32'(bus2.frame_err), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap3 g2 frame_err b", 32'(bus2.frame_err), 32'd0);
        chk("gap3 g2 busy b",      32'(bus2.busy),      32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap3 g2 frame_err c", 32'(bus2.frame_err), 32'd1);
        chk("gap3 g2 busy c",      32'(bus2.busy),      32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap3 g2 frame_err end", 32'(bus2.frame_err), 32'd0);
        chk("gap3 g2 valid_out",     32'(bus2.valid_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
